// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
//   UART receive controller. Detects the start bit on rx_in, runs the
//   oversample tick counter (edge_cnt) and enable (sample_data_en) for an
//   external data_sampling stage, and consumes the voted sampled_bit once per
//   bit period. The frame is deserialised LSB first, then the optional parity
//   bit and the stop bit are checked. A good frame updates p_data with a
//   one-cycle data_valid pulse; a bad one pulses par_err or stp_err instead.
//
// Ports
//   clk            in   1           single clock domain
//   rst            in   1           synchronous, active-high reset
//   rx_in          in   1           serial line, idle high, already synchronised
//   prescale       in   6           oversampling ratio (4, 8, 16, 32)
//   par_en         in   1           1 = parity bit follows the data bits
//   par_typ        in   1           0 = even parity, 1 = odd parity
//   sampled_bit    in   1           voted bit from data_sampling
//   edge_cnt       out  6           tick index within current bit period
//   sample_data_en out  1           enables data_sampling outside IDLE
//   p_data         out  DATA_WIDTH  last good payload
//   data_valid     out  1           one-cycle pulse, p_data updated
//   par_err        out  1           one-cycle pulse, parity mismatch
//   stp_err        out  1           one-cycle pulse, stop bit sampled 0
// -----------------------------------------------------------------------------
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  sampled_bit,
  output logic [5:0]            edge_cnt,
  output logic                  sample_data_en,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            presc_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  err_p_q;
  logic                  bit_end;
  logic                  last_data_bit;

  // Last tick of the current bit period; never asserted while idle, where
  // presc_q may still hold its cleared value.
  assign bit_end        = (state_q != IDLE) && (edge_cnt == presc_q - 6'd1);
  assign last_data_bit  = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign sample_data_en = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every register uses non-blocking assignment so all flops update
    // together from pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default is assigned before the case so no path leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!rx_in) state_d = START;
      START:   if (bit_end) state_d = sampled_bit ? IDLE : DATA;
      DATA:    if (bit_end && last_data_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tick counter, latched configuration, deserialiser and result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is a plain register, not a memory, so it is
      // cleared here along with everything else; a reset mid-frame leaves no
      // trace of the partial payload.
      edge_cnt   <= '0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      err_p_q    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state_q == IDLE) begin
        edge_cnt  <= '0;
        bit_cnt_q <= '0;
        err_p_q   <= 1'b0;
        if (!rx_in) begin
          // Ratios below 4 leave the sampler no room to vote; clamp them.
          presc_q   <= (prescale < 6'd4) ? 6'd4 : prescale;
          par_en_q  <= par_en;
          par_typ_q <= par_typ;
        end
      end else begin
        edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
      end

      if (bit_end) begin
        unique case (state_q)
          DATA: begin
            shift_q   <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
          PARITY: err_p_q <= (sampled_bit != (^shift_q ^ par_typ_q));
          STOP: begin
            if (!sampled_bit) begin
              stp_err <= 1'b1;
            end else if (err_p_q) begin
              par_err <= 1'b1;
            end else begin
              data_valid <= 1'b1;
              p_data     <= shift_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
//   Directed bench for uart_rx_fsm. A small behavioural sampler stands in for
//   data_sampling: it captures rx_in at the middle tick of each bit period.
//   Serial frames are driven bit by bit; result pulses are counted on the
//   falling edge and compared against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       sampled_bit;
  logic [5:0] edge_cnt;
  logic       sample_data_en;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  int start_cyc  = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int dv_cyc = 0;
  logic [7:0] dv_first = 8'h00;

  uart_rx_fsm #(.DATA_WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_in          (rx_in),
    .prescale       (prescale),
    .par_en         (par_en),
    .par_typ        (par_typ),
    .sampled_bit    (sampled_bit),
    .edge_cnt       (edge_cnt),
    .sample_data_en (sample_data_en),
    .p_data         (p_data),
    .data_valid     (data_valid),
    .par_err        (par_err),
    .stp_err        (stp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural sampler: mid-bit capture of the line.
  always @(posedge clk) begin
    if (rst)
      sampled_bit <= 1'b1;
    else if (sample_data_en && edge_cnt == (prescale >> 1))
      sampled_bit <= rx_in;
  end

  // Pulse monitor.
  always @(negedge clk) begin
    if (data_valid) begin
      if (dv_cnt == 0) dv_first = p_data;
      dv_cnt = dv_cnt + 1;
      dv_cyc = cyc;
    end
    if (par_err) pe_cnt = pe_cnt + 1;
    if (stp_err) se_cnt = se_cnt + 1;
  end

  task automatic clear_counts();
    dv_cnt = 0;
    pe_cnt = 0;
    se_cnt = 0;
  endtask

  task automatic send_frame(input int ps, input logic [7:0] d, input logic pen,
                            input logic ptyp, input logic pbit, input logic stop);
    @(posedge clk); #1;
    prescale  = ps[5:0];
    par_en    = pen;
    par_typ   = ptyp;
    rx_in     = 1'b0;
    start_cyc = cyc;
    repeat (ps) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (ps) @(posedge clk); #1;
    end
    if (pen) begin
      rx_in = pbit;
      repeat (ps) @(posedge clk); #1;
    end
    rx_in = stop;
    repeat (ps) @(posedge clk); #1;
    rx_in = 1'b1;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    assertions++;
    if ({edge_cnt, sample_data_en, p_data, data_valid, par_err, stp_err} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs: got edge_cnt=%0d en=%b p_data=%h dv=%b pe=%b se=%b, need all 0",
               edge_cnt, sample_data_en, p_data, data_valid, par_err, stp_err);
    end
  endtask

  task automatic test_good_frame();
    clear_counts();
    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    assertions++;
    if (dv_cnt !== 1 || pe_cnt !== 0 || se_cnt !== 0) begin
      failures++;
      $display("FAIL good_frame_pulses: got dv=%0d pe=%0d se=%0d, need 1 0 0", dv_cnt, pe_cnt, se_cnt);
    end
    assertions++;
    if (p_data !== 8'hA5) begin
      failures++;
      $display("FAIL good_frame_data: got %h, need a5", p_data);
    end
    assertions++;
    if (dv_cyc - start_cyc !== 81) begin
      failures++;
      $display("FAIL good_frame_latency: got %0d, need 81", dv_cyc - start_cyc);
    end
  endtask

  task automatic test_parity_error();
    clear_counts();
    send_frame(8, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    assertions++;
    if (pe_cnt !== 1 || dv_cnt !== 0 || se_cnt !== 0) begin
      failures++;
      $display("FAIL parity_err_pulses: got dv=%0d pe=%0d se=%0d, need 0 1 0", dv_cnt, pe_cnt, se_cnt);
    end
    assertions++;
    if (p_data !== 8'hA5) begin
      failures++;
      $display("FAIL parity_err_data: got %h, need a5", p_data);
    end
  endtask

  task automatic test_stop_error();
    clear_counts();
    send_frame(16, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    assertions++;
    if (se_cnt !== 1 || dv_cnt !== 0 || pe_cnt !== 0) begin
      failures++;
      $display("FAIL stop_err_pulses: got dv=%0d pe=%0d se=%0d, need 0 0 1", dv_cnt, pe_cnt, se_cnt);
    end
    assertions++;
    if (sample_data_en !== 1'b0 || edge_cnt !== 6'd0 || p_data !== 8'hA5) begin
      failures++;
      $display("FAIL stop_err_idle: got en=%b edge_cnt=%0d p_data=%h, need 0 0 a5",
               sample_data_en, edge_cnt, p_data);
    end
    clear_counts();
    send_frame(16, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    assertions++;
    if (dv_cnt !== 1 || se_cnt !== 0 || p_data !== 8'h55) begin
      failures++;
      $display("FAIL after_stop_err_frame: got dv=%0d se=%0d p_data=%h, need 1 0 55", dv_cnt, se_cnt, p_data);
    end
  endtask

  // Short low pulse on the line with ratio ps; the effective ratio is eff.
  task automatic glitch(input int ps, input int low_clks, input int eff, input string name);
    clear_counts();
    @(posedge clk); #1;
    prescale = ps[5:0];
    rx_in    = 1'b0;
    repeat (low_clks) @(posedge clk); #1;
    rx_in = 1'b1;
    // First START cycle is one edge after the line went low; last tick is eff-1.
    repeat (eff - low_clks) @(posedge clk); #1;
    assertions++;
    if (edge_cnt !== 6'(eff - 1) || sample_data_en !== 1'b1) begin
      failures++;
      $display("FAIL %s_last_tick: got edge_cnt=%0d en=%b, need %0d 1", name, edge_cnt, sample_data_en, eff - 1);
    end
    @(posedge clk); #1;
    assertions++;
    if (sample_data_en !== 1'b0 || edge_cnt !== 6'd0) begin
      failures++;
      $display("FAIL %s_abort: got en=%b edge_cnt=%0d, need 0 0", name, sample_data_en, edge_cnt);
    end
    settle();
    assertions++;
    if (dv_cnt + pe_cnt + se_cnt !== 0 || sample_data_en !== 1'b0) begin
      failures++;
      $display("FAIL %s_no_pulse: got pulses=%0d en=%b, need 0 0", name, dv_cnt + pe_cnt + se_cnt, sample_data_en);
    end
  endtask

  task automatic test_glitch();
    glitch(8, 2, 8, "glitch_ps8");
    glitch(2, 1, 4, "glitch_ps_clamp");
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_frame(4, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(32, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    assertions++;
    if (dv_cnt !== 2 || pe_cnt !== 0 || se_cnt !== 0) begin
      failures++;
      $display("FAIL b2b_pulses: got dv=%0d pe=%0d se=%0d, need 2 0 0", dv_cnt, pe_cnt, se_cnt);
    end
    assertions++;
    if (dv_first !== 8'h00 || p_data !== 8'hFF) begin
      failures++;
      $display("FAIL b2b_data: got first=%h last=%h, need 00 ff", dv_first, p_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    fork
      send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (36) @(posedge clk); #1;
        assertions++;
        if (sample_data_en !== 1'b1) begin
          failures++;
          $display("FAIL mid_frame_active: got en=%b, need 1", sample_data_en);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        assertions++;
        if (edge_cnt !== 6'd0 || sample_data_en !== 1'b0 || p_data !== 8'h00) begin
          failures++;
          $display("FAIL mid_frame_reset: got edge_cnt=%0d en=%b p_data=%h, need 0 0 00",
                   edge_cnt, sample_data_en, p_data);
        end
      end
    join
    settle();
    assertions++;
    if (dv_cnt + pe_cnt + se_cnt !== 0 || sample_data_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_frame_no_pulse: got pulses=%0d en=%b, need 0 0", dv_cnt + pe_cnt + se_cnt, sample_data_en);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  // Hard ceiling on run time.
  initial begin
    #500000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule
